// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width plus the hazard unit's forwarding
// select and sequencer state encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_IDLE  = 2'b00,
        HZ_BUSY  = 2'b01,
        HZ_DRAIN = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hz_perf_cnt.sv
// Stall/flush performance counters: free-running, wrap modulo 2^XLEN,
// each advanced by its own increment enable.
module hz_perf_cnt
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_inc,
    input  logic              flush_inc,
    output logic [XLEN_P-1:0] stall_cnt,
    output logic [XLEN_P-1:0] flush_cnt
);

    logic [XLEN_P-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN_P-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stalls, branch flushes
// and the mul/div start/done sequencer that freezes the front of the pipe.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              LoadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MdStartE,
    input  logic              MdDone,
    output logic              MdGo,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [XLEN_P-1:0] StallCnt,
    output logic [XLEN_P-1:0] FlushCnt
);

    hz_state_e state_q, state_d;
    fwd_sel_e  fwd_a, fwd_b;
    logic      lwstall;
    logic      flush_inc;

    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (RegWriteM && RdM != '0 && RdM == Rs1E)      fwd_a = FWD_MEM;
        else if (RegWriteW && RdW != '0 && RdW == Rs1E) fwd_a = FWD_WB;
        if (RegWriteM && RdM != '0 && RdM == Rs2E)      fwd_b = FWD_MEM;
        else if (RegWriteW && RdW != '0 && RdW == Rs2E) fwd_b = FWD_WB;
    end

    assign lwstall = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);

    // Outputs must react in the same cycle as the request, so they decode
    // from the current state and inputs rather than coming from flops.
    always_comb begin
        state_d   = state_q;
        MdGo      = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        flush_inc = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if (rst) begin
            state_d   = HZ_IDLE;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAE = FWD_NONE;
            ForwardBE = FWD_NONE;
        end else begin
            case (state_q)
                HZ_IDLE: begin
                    if (MdStartE) begin
                        MdGo    = 1'b1;
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        FlushM  = 1'b1;
                        state_d = HZ_BUSY;
                    end else if (PCSrcE) begin
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        flush_inc = 1'b1;
                    end else if (lwstall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                HZ_BUSY: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    if (MdDone) state_d = HZ_DRAIN;
                end
                HZ_DRAIN: state_d = HZ_IDLE;
                default:  state_d = HZ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= HZ_IDLE;
        else     state_q <= state_d;
    end

    hz_perf_cnt #(.XLEN_P(XLEN_P)) u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (StallF),
        .flush_inc (flush_inc),
        .stall_cnt (StallCnt),
        .flush_cnt (FlushCnt)
    );

endmodule
